// File: rtl/cache_nway_rr_if.sv
// Request/response and memory handshake bundle for cache_nway_rr.
//   slave  : cache side. It takes CPU requests and memory responses, and
//            drives the CPU response and the memory request.
//   master : environment side. It acts as the CPU and the memory model.
// Signals:
//   req_valid/req_ready/req_wr/req_addr/req_wdata : CPU request handshake
//   resp_valid/resp_data/resp_hit                 : completion pulse + result
//   mem_req/mem_wr/mem_addr/mem_wdata             : memory request, held until ack
//   mem_ack/mem_rdata                             : one-cycle memory completion
interface cache_nway_rr_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_hit;
  logic              mem_req;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_data, resp_hit,
           mem_req, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_data, resp_hit,
           mem_req, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_nway_rr.sv
// cache_nway_rr: N-way set-associative, write-through, one-word-line cache.
// It has per-set round-robin replacement. A write updates a line only when
// it hits; a write miss does not allocate a line.
// Ports:
//   clk, rst_n : rising-edge clock; asynchronous active-low reset
//   bus        : cache_nway_rr_if.slave (CPU request/response + memory req/ack)
//   hit_cnt, miss_cnt : saturating 32-bit response counters. They exist
//                       only when CACHE_NWAY_STATS_EN is defined.
// Optional feature macro: CACHE_NWAY_STATS_EN
module cache_nway_rr #(
  parameter int WAYS   = 2,
  parameter int SETS   = 32,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cache_nway_rr_if.slave       bus
`ifdef CACHE_NWAY_STATS_EN
  ,
  output logic [31:0]          hit_cnt,
  output logic [31:0]          miss_cnt
`endif
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int RR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_RD, MEM_WR, RESP} state_t;
  state_t state, state_nx;

  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              hit_q;
  logic [DATA_W-1:0] resp_data_q;
  logic              resp_hit_q;

  logic [SETS-1:0][WAYS-1:0] vld;
  logic [SETS-1:0][RR_W-1:0] rr;
  logic [TAG_W-1:0]          tag_mem  [SETS][WAYS];
  logic [DATA_W-1:0]         data_mem [SETS][WAYS];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  assign idx = addr_q[IDX_W-1:0];
  assign tag = addr_q[ADDR_W-1:IDX_W];

  logic [WAYS-1:0] match, inval;
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign match[w] = vld[idx][w] && (tag_mem[idx][w] == tag);
    assign inval[w] = !vld[idx][w];
  end

  // The loops scan downward, so the lowest matching way and the lowest
  // invalid way are the ones that win.
  logic            hit, has_inv;
  logic [RR_W-1:0] hit_way, vic_way;
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    vic_way = rr[idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (match[w]) begin
        hit     = 1'b1;
        hit_way = RR_W'(w);
      end
      if (inval[w]) begin
        has_inv = 1'b1;
        vic_way = RR_W'(w);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (bus.req_valid) state_nx = LOOKUP;
      LOOKUP: state_nx = wr_q ? MEM_WR : (hit ? RESP : MEM_RD);
      MEM_RD: if (bus.mem_ack) state_nx = RESP;
      MEM_WR: if (bus.mem_ack) state_nx = RESP;
      RESP:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The memory request is decoded from the state, so an asynchronous reset
  // drops mem_req at once.
  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.mem_req    = (state == MEM_RD) || (state == MEM_WR);
  assign bus.mem_wr     = (state == MEM_WR);
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_hit   = resp_hit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      hit_q       <= 1'b0;
      resp_data_q <= '0;
      resp_hit_q  <= 1'b0;
      vld         <= '0;
      rr          <= '0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          addr_q  <= bus.req_addr;
          wr_q    <= bus.req_wr;
          wdata_q <= bus.req_wdata;
        end
        LOOKUP: begin
          hit_q <= hit;
          if (!wr_q && hit) begin
            resp_data_q <= data_mem[idx][hit_way];
            resp_hit_q  <= 1'b1;
          end
        end
        MEM_RD: if (bus.mem_ack) begin
          vld[idx][vic_way] <= 1'b1;
          // The pointer moves only when a valid line is evicted.
          if (!has_inv)
            rr[idx] <= (rr[idx] == RR_W'(WAYS - 1)) ? '0 : rr[idx] + 1'b1;
          resp_data_q <= bus.mem_rdata;
          resp_hit_q  <= 1'b0;
        end
        MEM_WR: if (bus.mem_ack) resp_hit_q <= hit_q;
        default: ;
      endcase
    end
  end

  // Tag and data arrays have no reset. The valid bits gate them, and the
  // state is IDLE while reset is asserted, so no write can occur then.
  always_ff @(posedge clk) begin
    if (state == LOOKUP && wr_q && hit)
      data_mem[idx][hit_way] <= wdata_q;
    if (state == MEM_RD && bus.mem_ack) begin
      tag_mem[idx][vic_way]  <= tag;
      data_mem[idx][vic_way] <= bus.mem_rdata;
    end
  end

`ifdef CACHE_NWAY_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == RESP) begin
      if (resp_hit_q) begin
        if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
      end else begin
        if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_cache_nway_rr.sv
// Bench for cache_nway_rr (WAYS=2, SETS=4, ADDR_W=8). Requests come from a
// vector table. Expected responses are queued when a request is driven and
// popped by a monitor on resp_valid. The memory model acks 3 cycles after
// mem_req rises.
module tb_cache_nway_rr;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_nway_rr_if #(.ADDR_W(8), .DATA_W(32)) bus();

`ifdef CACHE_NWAY_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  cache_nway_rr #(.WAYS(2), .SETS(4), .DATA_W(32), .ADDR_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef CACHE_NWAY_STATS_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory model: the ack is set on a negedge, so the DUT samples it on the
  // following posedge.
  logic [31:0] mem [256];
  int          wait_cnt = 0;
  int          nmem = 0;
  logic [7:0]  last_maddr = '0;
  logic        last_mwr = 1'b0;
  initial begin
    for (int a = 0; a < 256; a++) mem[a] = {16'hA5A5, 8'h00, 8'(a)};
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
  end
  always @(negedge clk) begin
    if (!rst_n) begin
      wait_cnt = 0;
      bus.mem_ack = 1'b0;
    end else if (bus.mem_ack) begin
      bus.mem_ack = 1'b0;
    end else if (bus.mem_req) begin
      wait_cnt++;
      if (wait_cnt == 3) begin
        wait_cnt = 0;
        bus.mem_ack = 1'b1;
        bus.mem_rdata = mem[bus.mem_addr];
        if (bus.mem_wr) mem[bus.mem_addr] = bus.mem_wdata;
        last_maddr = bus.mem_addr;
        last_mwr = bus.mem_wr;
        nmem++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Scoreboard
  typedef struct { logic hit; logic [31:0] data; } exp_t;
  exp_t q[$];
  always @(negedge clk) begin
    if (rst_n && bus.resp_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_resp_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("resp_hit", 32'(bus.resp_hit), 32'(e.hit));
        chk("resp_data", bus.resp_data, e.data);
      end
    end
  end

  typedef struct {
    bit          rst;
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    bit          exp_hit;
    logic [31:0] exp_data;
    int          exp_mem;
  } vec_t;

  task automatic apply_reset();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic do_req(input vec_t v);
    int  n, m0;
    bit  got;
    exp_t e;
    if (v.rst) apply_reset();
    n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    bus.req_valid = 1'b1;
    bus.req_wr    = v.wr;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    m0 = nmem;
    e.hit = v.exp_hit;
    e.data = v.exp_data;
    q.push_back(e);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    n = 0;
    got = 0;
    while (n < 60 && !got) begin
      @(negedge clk);
      n++;
      if (n == 1) chk("ready_low_when_busy", 32'(bus.req_ready), 32'd0);
      if (bus.resp_valid) got = 1;
    end
    if (!got) begin
      chk("resp_timeout", 32'd0, 32'd1);
      q.delete();
    end else begin
      chk("latency", n, (v.exp_mem != 0) ? 32'd5 : 32'd2);
    end
    chk("mem_accesses", nmem - m0, v.exp_mem);
    if (v.exp_mem != 0) begin
      chk("mem_addr", 32'(last_maddr), 32'(v.addr));
      chk("mem_wr", 32'(last_mwr), 32'(v.wr));
    end
  endtask

  vec_t tbl[15];

  initial begin
    int n, rv;
    vec_t v;
    //          rst wr addr   wdata          hit data           mem
    tbl[0]  = '{1'b0, 1'b0, 8'h05, 32'h0,        1'b0, 32'hA5A5_0005, 1};
    tbl[1]  = '{1'b0, 1'b0, 8'h05, 32'h0,        1'b1, 32'hA5A5_0005, 0};
    tbl[2]  = '{1'b1, 1'b0, 8'h01, 32'h0,        1'b0, 32'hA5A5_0001, 1};
    tbl[3]  = '{1'b0, 1'b0, 8'h05, 32'h0,        1'b0, 32'hA5A5_0005, 1};
    tbl[4]  = '{1'b0, 1'b0, 8'h09, 32'h0,        1'b0, 32'hA5A5_0009, 1};
    tbl[5]  = '{1'b0, 1'b0, 8'h05, 32'h0,        1'b1, 32'hA5A5_0005, 0};
    tbl[6]  = '{1'b0, 1'b0, 8'h01, 32'h0,        1'b0, 32'hA5A5_0001, 1};
    tbl[7]  = '{1'b0, 1'b0, 8'h09, 32'h0,        1'b1, 32'hA5A5_0009, 0};
    tbl[8]  = '{1'b0, 1'b0, 8'h05, 32'h0,        1'b0, 32'hA5A5_0005, 1};
    tbl[9]  = '{1'b0, 1'b0, 8'h01, 32'h0,        1'b1, 32'hA5A5_0001, 0};
    tbl[10] = '{1'b0, 1'b1, 8'h05, 32'h1234_5678, 1'b1, 32'hA5A5_0001, 1};
    tbl[11] = '{1'b0, 1'b0, 8'h05, 32'h0,        1'b1, 32'h1234_5678, 0};
    tbl[12] = '{1'b0, 1'b1, 8'h0C, 32'hDEAD_BEEF, 1'b0, 32'h1234_5678, 1};
    tbl[13] = '{1'b0, 1'b0, 8'h0C, 32'h0,        1'b0, 32'hDEAD_BEEF, 1};
    tbl[14] = '{1'b0, 1'b0, 8'h0C, 32'h0,        1'b1, 32'hDEAD_BEEF, 0};

    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready",  32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_hit",   32'(bus.resp_hit), 32'd0);
    chk("rst_resp_data",  bus.resp_data, 32'd0);
    chk("rst_mem_req",    32'(bus.mem_req), 32'd0);
    chk("rst_mem_wr",     32'(bus.mem_wr), 32'd0);
    chk("rst_mem_addr",   32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata",  bus.mem_wdata, 32'd0);

    for (int i = 0; i < 15; i++) begin
      do_req(tbl[i]);
`ifdef CACHE_NWAY_STATS_EN
      if (i == 1) begin
        @(negedge clk);
        chk("hit_cnt", hit_cnt, 32'd1);
        chk("miss_cnt", miss_cnt, 32'd1);
      end
`endif
    end

    // Reset during MEM_RD aborts the access. Line 0x05 is cached at this
    // point and must be lost.
    n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b0;
    bus.req_addr  = 8'h11;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    n = 0;
    while (!bus.mem_req && n < 20) begin @(negedge clk); n++; end
    chk("abort_mem_req_seen", 32'(bus.mem_req), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("abort_mem_req_async", 32'(bus.mem_req), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    rv = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.resp_valid) rv++;
    end
    chk("abort_no_resp", rv, 32'd0);
    v = '{1'b0, 1'b0, 8'h05, 32'h0, 1'b0, 32'h1234_5678, 1};
    do_req(v);

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cache_nway_rr.md
Name: cache_nway_rr

Overview:
- Parametrised N-way set-associative, write-through, one-word-line cache sitting between the CPU load/store path and the ram model.
- Successor to the 2-way cache. Adds:
  - configurable ways, sets and widths;
  - an explicit valid/ready request handshake;
  - a req/ack memory handshake in place of a free-running RAM clock;
  - per-set round-robin replacement;
  - a write-update policy.

Parameters:
- WAYS, 2, associativity; any value >= 1.
- SETS, 32, number of sets; must be a power of two, >= 2.
- DATA_W, 32, data word width.
- ADDR_W, 32, word address width; must be > log2(SETS).

Ports:
- clk  in  1  Rising-edge clock.
- rst_n  in  1  Reset, asynchronous assert, active-low.
- req_valid  in  1  CPU request present.
- req_ready  out  1  Cache can accept a request.
- req_wr  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  Word address.
- req_wdata  in  DATA_W  Store data.
- resp_valid  out  1  One-cycle pulse: request complete.
- resp_data  out  DATA_W  Load data; held until the next resp_valid.
- resp_hit  out  1  Tag hit for the completed request; qualified by resp_valid.
- mem_req  out  1  Memory access request; held until mem_ack.
- mem_wr  out  1  Memory write; qualified by mem_req.
- mem_addr  out  ADDR_W  Memory address.
- mem_wdata  out  DATA_W  Memory write data.
- mem_ack  in  1  One-cycle memory completion; mem_rdata valid in the same cycle.
- mem_rdata  in  DATA_W  Memory read data.

Behaviour:
- Address split: index = req_addr[IDX_W-1:0], with IDX_W = log2(SETS); tag = req_addr[ADDR_W-1:IDX_W].
- Storage per set per way: valid bit, tag, data. Per set: round-robin pointer rr of width log2(WAYS), minimum 1 bit.
- Reset (rst_n low, asynchronous):
  - state = IDLE;
  - all valid bits = 0, all rr = 0;
  - req_ready = 1 once released; all other outputs 0.
  - Reset during a memory transaction aborts it: mem_req drops immediately, no resp_valid, no array update.
- FSM states: IDLE, LOOKUP, MEM_RD, MEM_WR, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid: register addr, wr and wdata; go to LOOKUP.
  - req_ready = 0 in every other state.
- LOOKUP:
  - Compare the tag against all valid ways of the set. Hit = any match; if several match (illegal), the lowest way wins.
  - Read hit: resp_data = way data, resp_hit = 1, go to RESP.
  - Read miss: go to MEM_RD.
  - Write, hit: update the hit way's data in this cycle, go to MEM_WR.
  - Write, miss: no allocate, go to MEM_WR.
- MEM_RD:
  - mem_req = 1, mem_wr = 0, mem_addr = registered address.
  - On mem_ack, choose the victim: lowest-index invalid way; if none is invalid, way rr, then rr = (rr+1) mod WAYS.
  - Write victim valid = 1, tag and mem_rdata.
  - resp_data = mem_rdata, resp_hit = 0, go to RESP.
- MEM_WR:
  - mem_req = 1, mem_wr = 1, mem_addr and mem_wdata = registered values.
  - On mem_ack: resp_hit = hit result from LOOKUP, go to RESP.
  - resp_data is unchanged on writes.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE.
- Latency from the accepting clock edge:
  - read hit: resp_valid 2 cycles later;
  - miss or write: 2 + memory cycles, counting the mem_ack cycle.
- mem_req stays asserted with stable mem_addr, mem_wr and mem_wdata until mem_ack. A mem_ack outside MEM_RD/MEM_WR is ignored.
- A request arriving while req_ready = 0 is not consumed; the requester holds req_valid.
- Back-to-back operation: the next request is accepted in the IDLE cycle after RESP, so at most one request is outstanding.
- rr advances only when a valid line is replaced, never on a fill into an invalid way.

Optional Feature:
- Macro: CACHE_NWAY_STATS_EN.
- Defined:
  - Extra outputs hit_cnt[31:0] and miss_cnt[31:0], reset to 0.
  - Exactly one counter increments per RESP cycle, selected by resp_hit.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: the ports and the counter logic do not exist.

Test Plan:
- WAYS=2, SETS=4, ADDR_W=8, mem_ack 3 cycles after mem_req. Read 0x05 with memory holding 0xA5A5_0005 -> mem_req read at 0x05; resp_valid with resp_hit=0 and resp_data=0xA5A5_0005. Read 0x05 again -> no mem_req; resp_valid 2 cycles after accept, resp_hit=1, same data.
- Reads 0x01, 0x05, 0x09 (all set 1) -> three misses; the third evicts way 0 (rr 0 -> 1). Re-read 0x05 -> hit. Re-read 0x01 -> miss, evicts way 1.
- Write 0x05 = 0x1234_5678 after 0x05 is cached -> mem write at 0x05, resp_hit=1. Then read 0x05 -> hit returning 0x1234_5678, no mem_req.
- Write to uncached 0x0C -> mem write, resp_hit=0. Read 0x0C -> miss (no allocate on write).
- Drop rst_n for 1 cycle while mem_req is high in MEM_RD -> mem_req falls asynchronously and no resp_valid follows. Then read the previously cached 0x05 -> miss.
- CACHE_NWAY_STATS_EN defined, sequence of scenario 1 -> hit_cnt=1, miss_cnt=1.
